// File: rtl/mips_mc_control_fsm.sv
// mips_mc_control_fsm: multicycle MIPS main control Moore FSM driving datapath enables and selects
module mips_mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t st, st_nx;

    assign state = st;

    // state register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else       st <= st_nx;
    end

    // next-state selection and Moore output decode
    always_comb begin
        st_nx         = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (st)
            FETCH: begin
                st_nx     = DECODE;
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: st_nx = MEMADR;
                    OP_RTYPE:     st_nx = EXEC;
                    OP_BEQ:       st_nx = BRANCH;
                    OP_ADDI:      st_nx = ADDIEX;
                    OP_J:         st_nx = JUMP;
                    default:      st_nx = FETCH;
                endcase
            end
            MEMADR: begin
                st_nx     = opcode == OP_LW ? MEMRD : opcode == OP_SW ? MEMWR : FETCH;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                st_nx    = MEMWB;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                st_nx     = ALUWB;
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            ADDIEX: begin
                st_nx     = ADDIWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: st_nx = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// tb_mips_mc_control_fsm: scoreboard bench for the multicycle MIPS control FSM
module tb_mips_mc_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [19:0] got;
    logic [19:0] q[$];
    logic [3:0] prev = 4'd0;
    int checks = 0;
    int fails = 0;

    mips_mc_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state)
    );

    always #5 clk = ~clk;

    assign got = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // hand-written output table: pcw pwc iord mrd mwr irw m2r rdst rw srca srcb aluop pcsrc
    function automatic logic [15:0] outs(input logic [3:0] s);
        case (s)
            4'd0:    return 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
            4'd1:    return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
            4'd2:    return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            4'd3:    return 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
            4'd4:    return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
            4'd5:    return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
            4'd6:    return 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
            4'd7:    return 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
            4'd8:    return 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
            4'd9:    return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            4'd10:   return 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
            4'd11:   return 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
            default: return 16'b0;
        endcase
    endfunction

    // one clock: drive inputs on the falling edge, queue the expected post-edge state and outputs
    task automatic cyc(input logic r, input logic [5:0] op, input logic [3:0] exp_st);
        @(negedge clk);
        reset = r;
        opcode = op;
        @(posedge clk);
        q.push_back({exp_st, outs(exp_st)});
        prev = exp_st;
    endtask

    // one instruction from FETCH; opcode is scrambled outside DECODE/MEMADR where it must be ignored
    task automatic run(input logic [5:0] op, input int n, input logic [19:0] seq);
        for (int i = 0; i < n; i++)
            cyc(1'b0, (prev == 4'd1 || prev == 4'd2) ? op : 6'($urandom), seq[19-4*i -: 4]);
    endtask

    // monitor: compare every presented cycle against the scoreboard and the exclusion rules
    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [19:0] e;
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL outputs st=%0d got=%b exp=%b", e[19:16], got, e);
            end
            checks++;
            if (mem_read && mem_write) begin
                fails++;
                $display("FAIL mem_rd_wr_excl st=%0d got=11 exp=not both", state);
            end
            checks++;
            if (reg_write && pc_write) begin
                fails++;
                $display("FAIL reg_pc_write_excl st=%0d got=11 exp=not both", state);
            end
        end
    end

    initial begin
        cyc(1'b1, 6'd0, 4'd0);
        cyc(1'b1, 6'd0, 4'd0);
        run(6'b100011, 5, {4'd1, 4'd2, 4'd3, 4'd4, 4'd0});
        run(6'b101011, 4, {4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
        run(6'b000000, 4, {4'd1, 4'd6, 4'd7, 4'd0, 4'd0});
        run(6'b001000, 4, {4'd1, 4'd9, 4'd10, 4'd0, 4'd0});
        run(6'b000100, 3, {4'd1, 4'd8, 4'd0, 4'd0, 4'd0});
        run(6'b000010, 3, {4'd1, 4'd11, 4'd0, 4'd0, 4'd0});
        run(6'b111111, 2, {4'd1, 4'd0, 4'd0, 4'd0, 4'd0});
        run(6'b101011, 3, {4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
        cyc(1'b1, 6'b101011, 4'd0);
        for (int k = 0; k < 6; k++) begin
            run(6'b100011, 5, {4'd1, 4'd2, 4'd3, 4'd4, 4'd0});
            run(6'b000100, 3, {4'd1, 4'd8, 4'd0, 4'd0, 4'd0});
            run(6'b101011, 4, {4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
            run(6'b111111, 2, {4'd1, 4'd0, 4'd0, 4'd0, 4'd0});
            run(6'b001000, 4, {4'd1, 4'd9, 4'd10, 4'd0, 4'd0});
            run(6'b000010, 3, {4'd1, 4'd11, 4'd0, 4'd0, 4'd0});
            run(6'b000000, 4, {4'd1, 4'd6, 4'd7, 4'd0, 4'd0});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
